// File: rtl/rx_intf_pkg.sv
// Shared constants and types for the RX-direction AXI-Stream master.
package rx_intf_pkg;

  localparam int TDATA_W     = 64;
  localparam int FIFO_ADDR_W = 12;
  localparam int NUM_SYM_W   = 14;
  localparam int DATA_CNT_W  = FIFO_ADDR_W + 1;
  localparam int PKT_CNT_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/rx_intf_m_axis_fifo.sv
// Single-clock first-word-fall-through FIFO: block RAM with a registered read
// port, followed by an output register that presents the head word.
module rx_intf_m_axis_fifo
  import rx_intf_pkg::*;
#(
  parameter int DATA_WIDTH = TDATA_W,
  parameter int ADDR_WIDTH = FIFO_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Pointers carry one extra wrap bit so equal pointers mean "RAM empty".
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;   // ram_rd_data holds a word
  logic                  out_valid_q, out_valid_d; // dout holds the head word
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic wr_accept, pop, ram_empty, out_load, rd_load;

  // Control: full is taken from the registered count, so it reflects the
  // state before any pop in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    full        = (count_q == FULL_COUNT);
    wr_accept   = wren && !full;
    pop         = rden && out_valid_q;
    ram_empty   = (wr_ptr_q == rd_ptr_q);
    out_load    = rd_valid_q && (!out_valid_q || pop);
    rd_load     = !ram_empty && (!rd_valid_q || out_load);

    wr_ptr_d    = wr_accept ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d    = rd_load ? rd_ptr_q + ONE : rd_ptr_q;

    rd_valid_d  = rd_valid_q;
    if (rd_load)       rd_valid_d = 1'b1;
    else if (out_load) rd_valid_d = 1'b0;

    out_valid_d = out_valid_q;
    if (out_load) out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;

    dout_d      = out_load ? ram_rd_data : dout_q;

    count_d     = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage and registered read port.
  // NOTE: the RAM array and its read register have no reset so they map onto
  // block RAM; the valid flags alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    if (rd_load)   ram_rd_data <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Pointer, count and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign empty      = !out_valid_q;
  assign data_count = count_q;

endmodule

// File: rtl/rx_intf_m_axis.sv
// AXI-Stream master returning buffered RX words to the host DMA: a software
// start pulse sends one packet of NUM_DMA_SYMBOL+1 words with TLAST on the end.
module rx_intf_m_axis
  import rx_intf_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH   = TDATA_W,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = NUM_SYM_W,
  parameter int FIFO_ADDR_WIDTH        = FIFO_ADDR_W
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
  input  logic                                WREN_FROM_ACC,
  input  logic                                START_1TRANS,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
  input  logic                                overflow_clear,
  output logic                                fifo_empty,
  output logic                                fifo_full,
  output logic [FIFO_ADDR_WIDTH:0]            data_count,
  output logic                                busy,
  output logic                                overflow_sticky,
  output logic                                start_ignored_sticky,
  output logic [PKT_CNT_W-1:0]                pkt_sent_count
);

  localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] WORD_ONE = {{(MAX_BIT_NUM_DMA_SYMBOL-1){1'b0}}, 1'b1};
  localparam logic [PKT_CNT_W-1:0]              PKT_ONE  = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

  logic clk, rst_n;
  assign clk   = M_AXIS_ACLK;
  assign rst_n = M_AXIS_ARESETN;

  state_e                              state_q, state_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_lat_q, num_lat_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   word_cnt_q, word_cnt_d;
  logic [PKT_CNT_W-1:0]                pkt_cnt_q, pkt_cnt_d;
  logic                                ovf_q, ovf_d;
  logic                                ign_q, ign_d;

  logic                                tvalid, tlast, handshake, last_hs;
  logic                                start_accept;

  rx_intf_m_axis_fifo #(
    .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wren       (WREN_FROM_ACC),
    .din        (DATA_FROM_ACC),
    .full       (fifo_full),
    .rden       (handshake),
    .dout       (M_AXIS_TDATA),
    .empty      (fifo_empty),
    .data_count (data_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start leaves IDLE, the TLAST handshake returns to it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START_1TRANS) state_d = SEND;
      SEND:    if (last_hs)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the stream is only offered while a packet is in progress.
  always_comb begin
    busy   = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (state_q == SEND) begin
      busy   = 1'b1;
      tvalid = !fifo_empty;
      tlast  = !fifo_empty && (word_cnt_q == num_lat_q);
    end
  end

  assign handshake    = tvalid && M_AXIS_TREADY;
  assign last_hs      = handshake && tlast;
  assign start_accept = START_1TRANS && (state_q == IDLE);

  // Packet length latch, beat counter, packet counter and sticky flags.
  // A set event in the same cycle as overflow_clear keeps the flag high.
  always_comb begin
    num_lat_d  = start_accept ? M_AXIS_NUM_DMA_SYMBOL : num_lat_q;

    word_cnt_d = word_cnt_q;
    if (start_accept)   word_cnt_d = '0;
    else if (handshake) word_cnt_d = word_cnt_q + WORD_ONE;

    pkt_cnt_d  = last_hs ? pkt_cnt_q + PKT_ONE : pkt_cnt_q;

    ovf_d = ovf_q;
    if (WREN_FROM_ACC && fifo_full) ovf_d = 1'b1;
    else if (overflow_clear)        ovf_d = 1'b0;

    ign_d = ign_q;
    if (START_1TRANS && (state_q == SEND)) ign_d = 1'b1;
    else if (overflow_clear)               ign_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat_q  <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      ign_q      <= 1'b0;
    end else begin
      num_lat_q  <= num_lat_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ovf_q      <= ovf_d;
      ign_q      <= ign_d;
    end
  end

  assign M_AXIS_TVALID        = tvalid;
  assign M_AXIS_TLAST         = tlast;
  assign M_AXIS_TSTRB         = '1;
  assign overflow_sticky      = ovf_q;
  assign start_ignored_sticky = ign_q;
  assign pkt_sent_count       = pkt_cnt_q;

endmodule

// File: tb/tb_rx_intf_m_axis.sv
// Self-checking bench for rx_intf_m_axis: a queue-based behavioural model
// compared against the DUT on every falling edge, plus directed scenarios
// with literal expectations.
module tb_rx_intf_m_axis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid, tlast;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tready = 1'b0;
  logic [63:0] din = '0;
  logic        wren = 1'b0;
  logic        start = 1'b0;
  logic [13:0] num = '0;
  logic        ovc = 1'b0;
  logic        fifo_empty, fifo_full, busy, ovs, sis;
  logic [12:0] data_count;
  logic [15:0] pkt;

  int checks = 0;
  int failures = 0;

  rx_intf_m_axis dut (
    .M_AXIS_ACLK           (clk),
    .M_AXIS_ARESETN        (rst_n),
    .M_AXIS_TVALID         (tvalid),
    .M_AXIS_TDATA          (tdata),
    .M_AXIS_TSTRB          (tstrb),
    .M_AXIS_TLAST          (tlast),
    .M_AXIS_TREADY         (tready),
    .DATA_FROM_ACC         (din),
    .WREN_FROM_ACC         (wren),
    .START_1TRANS          (start),
    .M_AXIS_NUM_DMA_SYMBOL (num),
    .overflow_clear        (ovc),
    .fifo_empty            (fifo_empty),
    .fifo_full             (fifo_full),
    .data_count            (data_count),
    .busy                  (busy),
    .overflow_sticky       (ovs),
    .start_ignored_sticky  (sis),
    .pkt_sent_count        (pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each buffered word remembers the first edge after which it may be at the
  // head: two edges after its write, and never before its predecessor leaves.
  typedef struct {
    logic [63:0] data;
    int          vis;
  } ent_t;

  ent_t mq[$];
  bit   m_send, m_ovs, m_sis;
  int   m_num, m_wcnt, m_pkts, cyc;
  bit   p_was_send, p_hv, p_tv, p_tl, p_hs, p_full;
  int   p_k;
  ent_t p_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_send = 0; m_ovs = 0; m_sis = 0;
      m_num = 0; m_wcnt = 0; m_pkts = 0;
    end else begin
      p_k        = cyc + 1;
      p_was_send = m_send;
      p_hv       = (mq.size() > 0) && (mq[0].vis <= cyc);
      p_tv       = m_send && p_hv;
      p_tl       = p_tv && (m_wcnt == m_num);
      p_hs       = p_tv && tready;
      p_full     = (mq.size() == 4096);
      if (p_hs) begin
        void'(mq.pop_front());
        m_wcnt++;
        if (p_tl) begin
          m_send = 0;
          m_pkts = (m_pkts + 1) % 65536;
        end
        if (mq.size() > 0) begin
          p_head = mq.pop_front();
          if (p_head.vis < p_k) p_head.vis = p_k;
          mq.push_front(p_head);
        end
      end
      if (wren && !p_full) mq.push_back('{din, p_k + 2});
      if (start && !p_was_send) begin
        m_send = 1;
        m_num  = int'(num);
        m_wcnt = 0;
      end
      if (wren && p_full) m_ovs = 1;
      else if (ovc)       m_ovs = 0;
      if (start && p_was_send) m_sis = 1;
      else if (ovc)            m_sis = 0;
      cyc = p_k;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit c_hv;
  always @(negedge clk) begin
    c_hv = (mq.size() > 0) && (mq[0].vis <= cyc);
    check("tvalid", tvalid, m_send && c_hv);
    if (m_send && c_hv) check("tdata", tdata, mq[0].data);
    check("tlast", tlast, m_send && c_hv && (m_wcnt == m_num));
    check("fifo_empty", fifo_empty, !c_hv);
    check("fifo_full", fifo_full, mq.size() == 4096);
    check("data_count", data_count, mq.size());
    check("busy", busy, m_send);
    check("overflow_sticky", ovs, m_ovs);
    check("start_ignored_sticky", sis, m_sis);
    check("pkt_sent_count", pkt, m_pkts);
    check("tstrb", tstrb, 8'hFF);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wren = 1'b1;
      din  = base + 64'(i);
      tick();
    end
    wren = 1'b0;
  endtask

  task automatic pulse_start(input logic [13:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  int          idx, nlast;
  bit          prev_stall;
  logic [63:0] prev_data;
  localparam logic [63:0] T4_BASE = 64'h4000_0000_0000_0000;

  initial begin
    // Reset state, checked while reset is held.
    #12;
    check("rst tvalid", tvalid, 1'b0);
    check("rst fifo_empty", fifo_empty, 1'b1);
    check("rst tdata", tdata, 64'h0);
    check("rst tstrb", tstrb, 8'hFF);
    check("rst busy", busy, 1'b0);
    check("rst data_count", data_count, 13'd0);
    #5 rst_n = 1'b1;
    tick();

    // T1: eight words streamed back-to-back with TREADY high.
    write_words(64'h1, 8);
    check("t1 data_count", data_count, 13'd8);
    tick(); tick();
    check("t1 idle tvalid", tvalid, 1'b0);
    tready = 1'b1;
    pulse_start(14'd7);
    check("t1 busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("t1 beat valid", tvalid, 1'b1);
      check("t1 beat data", tdata, 64'(i + 1));
      check("t1 beat last", tlast, i == 7);
      tick();
    end
    check("t1 pkt", pkt, 16'd1);
    check("t1 empty", fifo_empty, 1'b1);
    check("t1 busy end", busy, 1'b0);

    // T2: same packet with a pseudo-random TREADY.
    tready = 1'b0;
    write_words(64'h11, 8);
    tick(); tick();
    pulse_start(14'd7);
    idx = 0; nlast = 0; prev_stall = 0; prev_data = '0;
    for (int n = 0; n < 400 && busy; n++) begin
      tready = ($urandom_range(0, 1) == 1);
      if (prev_stall) begin
        check("t2 stall valid", tvalid, 1'b1);
        check("t2 stall data", tdata, prev_data);
      end
      if (tvalid && tready) begin
        check("t2 beat data", tdata, 64'h11 + 64'(idx));
        if (tlast) nlast++;
        idx++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      tick();
    end
    check("t2 beats", idx, 8);
    check("t2 tlast count", nlast, 1);
    check("t2 busy end", busy, 1'b0);
    check("t2 pkt", pkt, 16'd2);

    // T3: start on an empty FIFO, words trickle in five cycles apart.
    tready = 1'b1;
    pulse_start(14'd3);
    check("t3 busy", busy, 1'b1);
    check("t3 no data", tvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wren = 1'b1;
      din  = 64'h31 + 64'(i);
      tick();
      wren = 1'b0;
      check("t3 k+0 valid", tvalid, 1'b0);
      check("t3 k+0 count", data_count, 13'd1);
      tick();
      check("t3 k+1 valid", tvalid, 1'b0);
      tick();
      check("t3 k+2 valid", tvalid, 1'b1);
      check("t3 k+2 data", tdata, 64'h31 + 64'(i));
      check("t3 k+2 last", tlast, i == 3);
      tick(); tick();
    end
    check("t3 busy end", busy, 1'b0);
    check("t3 pkt", pkt, 16'd3);

    // T4: fill to depth, overflow, clear, then drain a 4096-word packet.
    write_words(T4_BASE, 4096);
    wren = 1'b1;
    din  = 64'hDEAD;
    tick(); tick();
    wren = 1'b0;
    check("t4 full", fifo_full, 1'b1);
    check("t4 overflow", ovs, 1'b1);
    check("t4 count", data_count, 13'd4096);
    wren = 1'b1;
    ovc  = 1'b1;
    tick();
    wren = 1'b0;
    check("t4 set wins", ovs, 1'b1);
    tick();
    ovc = 1'b0;
    check("t4 cleared", ovs, 1'b0);
    pulse_start(14'd4095);
    wren = 1'b1;
    din  = 64'hBAD;
    idx  = 0;
    for (int n = 0; n < 5000 && busy; n++) begin
      if (tvalid) begin
        check("t4 beat data", tdata, T4_BASE | 64'(idx));
        if (idx == 4095) check("t4 last", tlast, 1'b1);
        idx++;
      end
      tick();
      wren = 1'b0;
    end
    check("t4 beats", idx, 4096);
    check("t4 drop on full pop", ovs, 1'b1);
    check("t4 empty", fifo_empty, 1'b1);
    check("t4 pkt", pkt, 16'd4);
    ovc = 1'b1;
    tick();
    ovc = 1'b0;

    // T5: starts while busy and coincident with the final handshake.
    tready = 1'b0;
    write_words(64'h51, 10);
    tick(); tick();
    pulse_start(14'd0);
    check("t5 busy", busy, 1'b1);
    check("t5 last 1-word", tlast, 1'b1);
    pulse_start(14'd5);
    check("t5 ignored", sis, 1'b1);
    check("t5 len kept", tlast, 1'b1);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("t5 done", busy, 1'b0);
    check("t5 pkt", pkt, 16'd5);
    ovc = 1'b1;
    tick();
    ovc = 1'b0;
    check("t5 sticky clr", sis, 1'b0);
    tready = 1'b1;
    pulse_start(14'd2);
    for (int i = 0; i < 3; i++) begin
      check("t5b beat data", tdata, 64'h52 + 64'(i));
      if (i == 2) begin
        start = 1'b1;
        num   = 14'd1;
      end
      tick();
      start = 1'b0;
    end
    check("t5b busy", busy, 1'b0);
    check("t5b ignored", sis, 1'b1);
    check("t5b pkt", pkt, 16'd6);
    check("t5b count", data_count, 13'd6);

    // T6: reset in the middle of a 10-word packet.
    tready = 1'b0;
    write_words(64'h61, 4);
    tick(); tick();
    tready = 1'b1;
    pulse_start(14'd9);
    tick(); tick(); tick();
    check("t6 mid valid", tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6 rst tvalid", tvalid, 1'b0);
    check("t6 rst busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("t6 count", data_count, 13'd0);
    check("t6 busy", busy, 1'b0);
    check("t6 pkt", pkt, 16'd0);
    check("t6 empty", fifo_empty, 1'b1);
    check("t6 tdata", tdata, 64'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_intf_m_axis.md
# rx_intf_m_axis

AXI-Stream master that returns received baseband data to the host DMA. It buffers 64-bit words produced by the RX accumulator in an internal FIFO. On a software start pulse it emits exactly NUM_DMA_SYMBOL+1 words as one AXIS packet, with TLAST on the final word. It is the RX-direction counterpart of the TX-side AXIS slave: a FIFO writer on the fabric side and an AXIS master on the DMA side.

## Interface
- C_M_AXIS_TDATA_WIDTH, 64, stream word width
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of the packet length field
- FIFO_ADDR_WIDTH, 12, FIFO depth is 2^FIFO_ADDR_WIDTH = 4096 words
- M_AXIS_ACLK  in  1  single clock; everything is rising-edge
- M_AXIS_ARESETN  in  1  asynchronous, active-low reset
- M_AXIS_TVALID  out  1  AXIS valid
- M_AXIS_TDATA  out  64  AXIS data, taken from the FIFO head
- M_AXIS_TSTRB  out  8  constant all-ones
- M_AXIS_TLAST  out  1  marks the last word of a packet
- M_AXIS_TREADY  in  1  AXIS ready from the DMA
- DATA_FROM_ACC  in  64  word to buffer
- WREN_FROM_ACC  in  1  write strobe for DATA_FROM_ACC
- START_1TRANS  in  1  one-cycle pulse that starts a packet
- M_AXIS_NUM_DMA_SYMBOL  in  14  packet length minus 1; latched on start
- overflow_clear  in  1  clears the sticky flags
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full
- data_count  out  13  words currently in the FIFO
- busy  out  1  high while in SEND
- overflow_sticky  out  1  a write was dropped
- start_ignored_sticky  out  1  a start arrived while busy
- pkt_sent_count  out  16  completed packets, wraps

## Operation
- FSM states:
  - IDLE: on START_1TRANS, latch num_lat <= M_AXIS_NUM_DMA_SYMBOL, set word_cnt <= 0, go to SEND.
  - SEND: M_AXIS_TVALID = !fifo_empty. A handshake is TVALID && TREADY; each handshake pops one word and increments word_cnt.
  - M_AXIS_TLAST = SEND && TVALID && (word_cnt == num_lat).
  - A handshake with TLAST=1 returns the FSM to IDLE and increments pkt_sent_count.
- TVALID is never asserted in IDLE, even when data is buffered.
- num_lat = 0 gives a 1-word packet. num_lat = 16383 gives 16384 words; packets may exceed FIFO depth because data streams through.
- Write side: a word is accepted when WREN_FROM_ACC && !fifo_full.
  - WREN_FROM_ACC while fifo_full drops the word and sets overflow_sticky.
  - fifo_full is evaluated before any same-cycle pop, so a write while full is dropped even if a read happens in that cycle.
- START_1TRANS in SEND is ignored and sets start_ignored_sticky.
- overflow_clear clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- data_count: +1 per accepted write, −1 per handshake, unchanged when both occur. It saturates logically at 4096 because full blocks writes.
- M_AXIS_TDATA/TVALID hold stable while TVALID=1 and TREADY=0 (AXIS rule).

## Timing
- Reset (asynchronous assert, synchronous release): every output is 0 except fifo_empty=1 and TSTRB=all-ones. FSM goes to IDLE and FIFO pointers clear.
- Reset asserted mid-packet aborts the packet with no TLAST and flushes buffered data.
- FIFO is first-word-fall-through. A word written at edge k into an empty FIFO appears at the head (TDATA, and TVALID if in SEND) after edge k+2. Write-to-data_count latency is 1 cycle.
- START_1TRANS at edge k: busy=1 after edge k. If data is buffered, TVALID is high in the same cycle.
- With TREADY held high and the FIFO non-empty: one word per cycle, with no bubble between words.
- The last handshake at edge k: busy=0 and TVALID=0 after edge k, and pkt_sent_count updates at edge k. A new START_1TRANS is accepted at edge k+1 or later.
- START_1TRANS coincident with the final TLAST handshake is ignored and flagged.

## Structure
- Package rx_intf_pkg:
  - FIFO_ADDR_WIDTH and TDATA width constants.
  - State enum {IDLE, SEND}.
  - Count widths: 13-bit data_count, 16-bit pkt_sent_count.
- Sub-module rx_intf_m_axis_fifo:
  - Single-clock FWFT FIFO on block RAM, with a registered output stage.
  - Ports: wren/din/full, rden/dout/empty, data_count.
- The top level holds the FSM, counters, sticky flags and AXIS output mapping.

## Test plan
- Write 8 words 0x1..0x8, then pulse START with NUM=7, TREADY=1 → 8 consecutive beats 0x1..0x8; TLAST only on 0x8; pkt_sent_count=1; fifo_empty=1.
- Same stimulus with TREADY toggled pseudo-randomly → data order preserved; TDATA/TVALID stable during stalls; exactly one TLAST.
- START with NUM=3 while the FIFO is empty, then write 4 words spaced 5 cycles apart → each beat's TVALID rises 2 cycles after its write; TLAST on the 4th word.
- Fill 4096 words, write 2 more, then pulse overflow_clear → fifo_full=1 and overflow_sticky=1 after the extra writes; sticky cleared by overflow_clear; the data read out is the original 4096 words.
- START during SEND (NUM=0 then NUM=5 mid-packet) → second start ignored, start_ignored_sticky=1, first packet length unchanged.
- Assert reset after 3 of 10 beats → TVALID=0 immediately; after release data_count=0, busy=0, pkt_sent_count=0.
